// File: rtl/riscv_alu_issue.sv
// riscv_alu_issue
// ---------------
// Execute-stage issue block. Decodes an RV32I instruction together with its
// register-file operands and PC into an ALU opcode (ALU_Ctrl) and the two
// ALU operands (A, B), then registers the result behind a valid/ready
// interface backed by a 2-entry skid buffer (output register + skid register)
// so that the upstream decode/regfile stage and the downstream ALU stage can
// stall independently.
//
// ALU_Ctrl encoding: 0 AND, 1 OR, 2 ADD, 6 SUB, 7 SLT. Encodings this block
// cannot map onto the ALU are still issued, with illegal=1 and
// ALU_Ctrl/A/B forced to zero, so the downstream stage can trap on them.
//
// Ports:
//   clk          rising-edge clock
//   reset        asynchronous, active-high reset (clears both buffer entries)
//   in_valid     upstream instruction valid
//   in_ready     block can accept an instruction (registered: skid empty)
//   instr        RV32I instruction word
//   rs1_data     register source 1 value
//   rs2_data     register source 2 value
//   pc           instruction address
//   out_valid    issued op valid
//   out_ready    ALU stage accepts op
//   ALU_Ctrl     ALU opcode
//   A, B         ALU operands
//   illegal      op is not supported by the ALU encoding
//   issue_count  count of legal ops transferred out
//
// Optional feature (macro RISCV_ALU_ISSUE_PERF_EN):
//   defined   -> issue_count counts output transfers with illegal=0, wraps
//                at 2^32 and is cleared by reset.
//   undefined -> issue_count is tied to zero; no counter is built.

module riscv_alu_issue #(
  parameter int XLEN   = 32,
  parameter int CTRL_W = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [31:0]       instr,
  input  logic [XLEN-1:0]   rs1_data,
  input  logic [XLEN-1:0]   rs2_data,
  input  logic [XLEN-1:0]   pc,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] ALU_Ctrl,
  output logic [XLEN-1:0]   A,
  output logic [XLEN-1:0]   B,
  output logic              illegal,
  output logic [31:0]       issue_count
);

  // --------------------------------------------------------------------------
  // Encodings
  // --------------------------------------------------------------------------
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  // NOR (12) exists in the ALU but no RV32I op maps onto it, so it is never
  // produced here.
  localparam logic [CTRL_W-1:0] ALU_AND = CTRL_W'(0);
  localparam logic [CTRL_W-1:0] ALU_OR  = CTRL_W'(1);
  localparam logic [CTRL_W-1:0] ALU_ADD = CTRL_W'(2);
  localparam logic [CTRL_W-1:0] ALU_SUB = CTRL_W'(6);
  localparam logic [CTRL_W-1:0] ALU_SLT = CTRL_W'(7);

  // One buffered issue slot.
  typedef struct packed {
    logic              ill;
    logic [CTRL_W-1:0] ctrl;
    logic [XLEN-1:0]   a;
    logic [XLEN-1:0]   b;
  } op_t;

  // --------------------------------------------------------------------------
  // Decode
  // --------------------------------------------------------------------------
  logic [6:0]      opc;
  logic [2:0]      f3;
  logic [6:0]      f7;
  logic [XLEN-1:0] imm_i;
  logic [XLEN-1:0] imm_s;
  logic [XLEN-1:0] imm_u;
  op_t             dec_op;
  op_t             raw_op;
  logic            dec_ill;

  assign opc = instr[6:0];
  assign f3  = instr[14:12];
  assign f7  = instr[31:25];

  assign imm_i = {{(XLEN-12){instr[31]}}, instr[31:20]};
  assign imm_s = {{(XLEN-12){instr[31]}}, instr[31:25], instr[11:7]};
  assign imm_u = XLEN'($signed({instr[31:12], 12'b0}));

  always_comb begin
    raw_op.ill  = 1'b0;
    raw_op.ctrl = ALU_ADD;
    raw_op.a    = rs1_data;
    raw_op.b    = rs2_data;
    dec_ill     = 1'b0;

    case (opc)
      OPC_OP: begin
        // Only the base f7 is legal for AND/OR/SLT; f3=000 also allows SUB.
        case (f3)
          3'b000: begin
            if (f7 == F7_BASE)     raw_op.ctrl = ALU_ADD;
            else if (f7 == F7_ALT) raw_op.ctrl = ALU_SUB;
            else                   dec_ill     = 1'b1;
          end
          3'b111: begin
            raw_op.ctrl = ALU_AND;
            dec_ill     = (f7 != F7_BASE);
          end
          3'b110: begin
            raw_op.ctrl = ALU_OR;
            dec_ill     = (f7 != F7_BASE);
          end
          3'b010: begin
            raw_op.ctrl = ALU_SLT;
            dec_ill     = (f7 != F7_BASE);
          end
          default: dec_ill = 1'b1;
        endcase
      end

      OPC_OP_IMM: begin
        raw_op.b = imm_i;
        case (f3)
          3'b000:  raw_op.ctrl = ALU_ADD;
          3'b111:  raw_op.ctrl = ALU_AND;
          3'b110:  raw_op.ctrl = ALU_OR;
          3'b010:  raw_op.ctrl = ALU_SLT;
          default: dec_ill     = 1'b1;
        endcase
      end

      // Address generation for memory ops: rs1 + offset.
      OPC_LOAD:  raw_op.b = imm_i;
      OPC_STORE: raw_op.b = imm_s;

      OPC_BRANCH: begin
        // BEQ/BNE test the SUB result for zero downstream; BLT uses SLT.
        case (f3)
          3'b000, 3'b001: raw_op.ctrl = ALU_SUB;
          3'b100:         raw_op.ctrl = ALU_SLT;
          default:        dec_ill     = 1'b1;
        endcase
      end

      OPC_LUI: begin
        raw_op.a = '0;
        raw_op.b = imm_u;
      end

      OPC_AUIPC: begin
        raw_op.a = pc;
        raw_op.b = imm_u;
      end

      default: dec_ill = 1'b1;
    endcase
  end

  // Illegal ops carry a clean zero payload so nothing downstream can act on
  // half-decoded operands.
  always_comb begin
    dec_op = raw_op;
    if (dec_ill) begin
      dec_op.ill  = 1'b1;
      dec_op.ctrl = '0;
      dec_op.a    = '0;
      dec_op.b    = '0;
    end
  end

  // --------------------------------------------------------------------------
  // Skid buffer
  // --------------------------------------------------------------------------
  op_t  out_op_reg;
  logic out_valid_reg;
  op_t  skid_op_reg;
  logic skid_valid_reg;

  logic accept;
  logic drain;
  logic out_free;

  // in_ready depends only on the skid register, so there is no combinational
  // path from out_ready back to in_ready.
  assign in_ready = ~skid_valid_reg;
  assign accept   = in_valid & in_ready;
  assign drain    = out_valid_reg & out_ready;
  // The output register can take a new op if it is empty or leaving now.
  assign out_free = drain | ~out_valid_reg;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_op_reg     <= '0;
      out_valid_reg  <= 1'b0;
      skid_op_reg    <= '0;
      skid_valid_reg <= 1'b0;
    end else begin
      if (out_free) begin
        if (skid_valid_reg) begin
          // Older op first. accept is necessarily 0 here because in_ready
          // was low while the skid register was full.
          out_op_reg     <= skid_op_reg;
          out_valid_reg  <= 1'b1;
          skid_valid_reg <= 1'b0;
        end else if (accept) begin
          out_op_reg    <= dec_op;
          out_valid_reg <= 1'b1;
        end else begin
          out_valid_reg <= 1'b0;
        end
      end else if (accept) begin
        // Output is stalled: park the new op; out_* stay untouched.
        skid_op_reg    <= dec_op;
        skid_valid_reg <= 1'b1;
      end
    end
  end

  assign out_valid = out_valid_reg;
  assign ALU_Ctrl  = out_op_reg.ctrl;
  assign A         = out_op_reg.a;
  assign B         = out_op_reg.b;
  assign illegal   = out_op_reg.ill;

  // --------------------------------------------------------------------------
  // Issue counter
  // --------------------------------------------------------------------------
`ifdef RISCV_ALU_ISSUE_PERF_EN
  logic [31:0] issue_count_reg;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      issue_count_reg <= '0;
    end else if (drain && !out_op_reg.ill) begin
      issue_count_reg <= issue_count_reg + 32'd1;
    end
  end

  assign issue_count = issue_count_reg;
`else
  assign issue_count = '0;
`endif

endmodule

// File: doc/riscv_alu_issue.md
Name: riscv_alu_issue

Overview:
- Execute-stage issue block that produces the ALU's control and operand inputs.
- Decodes an RV32I instruction, plus its register-file operands and PC, into ALU_Ctrl, A and B.
- Registers the result behind a valid/ready interface with a 2-entry skid buffer, so decode/regfile and the ALU stage can stall independently.
- Unsupported encodings are passed downstream flagged illegal; they are never silently dropped.

Parameters:
- XLEN, 32, datapath width of rs1/rs2/pc/A/B.
- CTRL_W, 4, width of ALU_Ctrl.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-high reset
- in_valid  input  1  upstream instruction valid
- in_ready  output  1  block can accept an instruction this cycle
- instr  input  32  RV32I instruction word
- rs1_data  input  XLEN  register source 1 value
- rs2_data  input  XLEN  register source 2 value
- pc  input  XLEN  instruction address
- out_valid  output  1  issued op valid
- out_ready  input  1  ALU stage accepts op
- ALU_Ctrl  output  CTRL_W  ALU opcode: 0 AND, 1 OR, 2 ADD, 6 SUB, 7 SLT
- A  output  XLEN  ALU operand A
- B  output  XLEN  ALU operand B
- illegal  output  1  op is not supported by the ALU encoding
- issue_count  output  32  issued-op counter (only with the optional feature)

Behaviour:
- Reset (async, active-high), all registers cleared:
  - out_valid=0, in_ready=1, ALU_Ctrl=0, A=0, B=0, illegal=0, skid empty, issue_count=0.
  - Reset asserted mid-operation discards both buffered entries immediately.
- Handshake:
  - Transfer in on in_valid&&in_ready; transfer out on out_valid&&out_ready.
  - Latency 1 cycle: an op accepted in cycle N is presented at out_* in cycle N+1 when the output register is free.
- Skid buffer (output register plus one skid register):
  - in_ready = skid register empty (registered, not combinational from out_ready).
  - Output empty, or output drains the same cycle: the incoming op loads the output register.
  - Output holds and out_ready=0 while an op is accepted: the op goes to the skid register and in_ready drops next cycle.
  - Output drains with skid full: skid moves to output and skid empties; in_ready=1 next cycle.
  - Skid full and output drains while in_valid=1: the new op is not accepted, since in_ready was 0 that cycle.
  - Ordering is strictly FIFO.
  - While out_valid=1 and out_ready=0, out_* are held stable.
- Decode (opc=instr[6:0], f3=instr[14:12], f7=instr[31:25]):
  - 0110011 R-type, A=rs1, B=rs2:
    - f3=000: f7=0000000 gives ADD; f7=0100000 gives SUB.
    - 111 gives AND; 110 gives OR; 010 gives SLT.
    - Any other f3/f7 combination is illegal.
  - 0010011 I-type, A=rs1, B=sign-extended instr[31:20]: f3 000 ADD, 111 AND, 110 OR, 010 SLT; other f3 is illegal.
  - 0000011 load: ADD, A=rs1, B=sign-extended I-immediate.
  - 0100011 store: ADD, A=rs1, B=sign-extended {instr[31:25],instr[11:7]}.
  - 1100011 branch, A=rs1, B=rs2: f3 000/001 gives SUB (zero-test downstream); 100 gives SLT; other f3 is illegal.
  - 0110111 LUI: ADD, A=0, B={instr[31:12],12'b0}.
  - 0010111 AUIPC: ADD, A=pc, B={instr[31:12],12'b0}.
  - Anything else: illegal=1, ALU_Ctrl=0, A=0, B=0.
- Encoding 12 (NOR) is never issued.
- illegal ops occupy a slot and handshake normally.

Optional Feature:
- Macro RISCV_ALU_ISSUE_PERF_EN.
- Defined: issue_count increments by 1 on each output transfer with illegal=0. It wraps 0xFFFFFFFF to 0 and is cleared by reset.
- Undefined: issue_count is tied to 0 and the counter logic is absent.

Test Plan:
- Reset mid-stall: 2 ops buffered, pulse reset -> out_valid=0, in_ready=1 immediately; no stale op appears after reset release.
- SUB x3,x1,x2 (0x402081B3) with rs1=10, rs2=3, out_ready=1 -> next cycle out_valid=1, ALU_Ctrl=6, A=10, B=3, illegal=0.
- ADDI with imm=0xFFF (0xFFF08093), rs1=5 -> ALU_Ctrl=2, B=0xFFFFFFFF.
- AUIPC (0x12345097) at pc=0x100 -> A=0x100, B=0x12345000, ALU_Ctrl=2.
- Backpressure: out_ready=0, send 3 back-to-back ops -> 2 accepted, in_ready=0. Release -> outputs emerge in order, 1 per cycle, with A/B stable while stalled.
- XOR (0x0020C1B3) -> illegal=1, ALU_Ctrl=0, A=B=0. With RISCV_ALU_ISSUE_PERF_EN, issue_count is unchanged by it and +1 for each legal op.
